// File: rtl/tl_fragmenter_arbiter_if.sv
// TileLink-UL port bundle (A and D channels) shared by the arbiter's
// upstream and downstream sides.
//   SRC_W      : source id width (2 upstream, 3 toward the fragmenter)
//   DATA_BYTES : beat width in bytes
// Modports:
//   master : issues A requests, accepts D responses
//   slave  : accepts A requests, returns D responses
interface tl_fragmenter_arbiter_if #(
  parameter int SRC_W      = 2,
  parameter int DATA_BYTES = 8
);
  localparam int DATA_W = DATA_BYTES * 8;

  logic                  a_valid;
  logic                  a_ready;
  logic [2:0]            a_opcode;
  logic [2:0]            a_param;
  logic [2:0]            a_size;
  logic [SRC_W-1:0]      a_source;
  logic [25:0]           a_address;
  logic [DATA_BYTES-1:0] a_mask;
  logic [DATA_W-1:0]     a_data;
  logic                  a_corrupt;

  logic                  d_valid;
  logic                  d_ready;
  logic [2:0]            d_opcode;
  logic [2:0]            d_size;
  logic [SRC_W-1:0]      d_source;
  logic [DATA_W-1:0]     d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address,
           a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_data,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address,
           a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_data,
    input  d_ready
  );
endinterface

// File: rtl/tl_fragmenter_arbiter.sv
// Two-requester TileLink-UL arbiter in front of the fragmenter input port.
// A channel: round-robin between in0/in1, locked for the length of a
// multi-beat data message and frozen while a beat waits for ready.
// D channel: steered back to the requester named by the source MSB.
// Both channels are purely combinational; only arbitration state is stored.
// Ports:
//   clock : sole clock
//   reset : asynchronous, active-low
//   in0   : requester 0 (slave side, 2-bit source)
//   in1   : requester 1 (slave side, 2-bit source)
//   out   : fragmenter port (master side, 3-bit source = {idx, in source})
//
// State registers:
//   register   | meaning
//   lock       | multi-beat burst in progress
//   lock_idx   | requester owning the burst
//   beats_left | beats remaining after the current one (0 on final beat)
//   held       | grant frozen: beat presented without ready
//   held_idx   | requester whose beat is frozen
//   last       | requester that most recently completed a message
module tl_fragmenter_arbiter (
  input logic clock,
  input logic reset,
  tl_fragmenter_arbiter_if.slave  in0,
  tl_fragmenter_arbiter_if.slave  in1,
  tl_fragmenter_arbiter_if.master out
);

  logic       lock,       lock_nx;
  logic       lock_idx,   lock_idx_nx;
  logic [3:0] beats_left, beats_left_nx;
  logic       held,       held_nx;
  logic       held_idx,   held_idx_nx;
  logic       last,       last_nx;

  logic       grant;
  logic       a_fire;
  logic [4:0] beat_cnt;
  logic       d_idx;

  // Data-bearing opcodes (opcode[2]==0) larger than one beat span
  // 2^(size-3) beats; everything else is a single beat.
  function automatic logic [4:0] beat_count(input logic [2:0] opcode,
                                            input logic [2:0] size);
    if (opcode[2] || size <= 3'd3) begin
      return 5'd1;
    end
    return 5'd1 << (size - 3'd3);
  endfunction

  always_comb begin
    grant = 1'b0;
    if (lock) begin
      grant = lock_idx;
    end else if (held) begin
      grant = held_idx;
    end else if (in0.a_valid && in1.a_valid) begin
      grant = ~last;
    end else if (in1.a_valid) begin
      grant = 1'b1;
    end
  end

  // A channel mux
  always_comb begin
    out.a_valid   = grant ? in1.a_valid   : in0.a_valid;
    out.a_opcode  = grant ? in1.a_opcode  : in0.a_opcode;
    out.a_param   = grant ? in1.a_param   : in0.a_param;
    out.a_size    = grant ? in1.a_size    : in0.a_size;
    out.a_source  = {grant, (grant ? in1.a_source : in0.a_source)};
    out.a_address = grant ? in1.a_address : in0.a_address;
    out.a_mask    = grant ? in1.a_mask    : in0.a_mask;
    out.a_data    = grant ? in1.a_data    : in0.a_data;
    out.a_corrupt = grant ? in1.a_corrupt : in0.a_corrupt;
    in0.a_ready   = out.a_ready & ~grant;
    in1.a_ready   = out.a_ready &  grant;
  end

  assign a_fire   = out.a_valid & out.a_ready;
  assign beat_cnt = beat_count(out.a_opcode, out.a_size);

  // D channel steering; payload is broadcast, only valid/ready are routed.
  assign d_idx = out.d_source[2];

  always_comb begin
    in0.d_valid  = out.d_valid & ~d_idx;
    in1.d_valid  = out.d_valid &  d_idx;
    out.d_ready  = d_idx ? in1.d_ready : in0.d_ready;
    in0.d_opcode = out.d_opcode;
    in1.d_opcode = out.d_opcode;
    in0.d_size   = out.d_size;
    in1.d_size   = out.d_size;
    in0.d_source = out.d_source[1:0];
    in1.d_source = out.d_source[1:0];
    in0.d_data   = out.d_data;
    in1.d_data   = out.d_data;
  end

  // Next-state logic
  always_comb begin
    lock_nx       = lock;
    lock_idx_nx   = lock_idx;
    beats_left_nx = beats_left;
    held_nx       = held;
    held_idx_nx   = held_idx;
    last_nx       = last;

    if (a_fire) begin
      held_nx = 1'b0;
    end else if (out.a_valid) begin
      held_nx     = 1'b1;
      held_idx_nx = grant;
    end

    if (a_fire) begin
      if (lock) begin
        if (beats_left == 4'd0) begin
          lock_nx = 1'b0;
          last_nx = grant;
        end else begin
          beats_left_nx = beats_left - 4'd1;
        end
      end else if (beat_cnt > 5'd1) begin
        // count-2 so the register reads 0 while the final beat is on the bus
        lock_nx       = 1'b1;
        lock_idx_nx   = grant;
        beats_left_nx = 4'(beat_cnt - 5'd2);
      end else begin
        last_nx = grant;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock       <= 1'b0;
      lock_idx   <= 1'b0;
      beats_left <= 4'd0;
      held       <= 1'b0;
      held_idx   <= 1'b0;
      last       <= 1'b1;
    end else begin
      lock       <= lock_nx;
      lock_idx   <= lock_idx_nx;
      beats_left <= beats_left_nx;
      held       <= held_nx;
      held_idx   <= held_idx_nx;
      last       <= last_nx;
    end
  end

endmodule

// File: tb/tb_tl_fragmenter_arbiter.sv
module tb_tl_fragmenter_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  tl_fragmenter_arbiter_if #(.SRC_W(2)) in0_if ();
  tl_fragmenter_arbiter_if #(.SRC_W(2)) in1_if ();
  tl_fragmenter_arbiter_if #(.SRC_W(3)) out_if ();

  tl_fragmenter_arbiter dut (
    .clock (clock),
    .reset (reset),
    .in0   (in0_if),
    .in1   (in1_if),
    .out   (out_if)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input int k, input logic v, input logic [2:0] op,
                       input logic [2:0] sz, input logic [1:0] src,
                       input logic [25:0] addr, input logic [63:0] data);
    if (k == 0) begin
      in0_if.a_valid = v; in0_if.a_opcode = op; in0_if.a_size = sz;
      in0_if.a_source = src; in0_if.a_address = addr; in0_if.a_data = data;
      in0_if.a_param = 3'd0; in0_if.a_mask = 8'hFF; in0_if.a_corrupt = 1'b0;
    end else begin
      in1_if.a_valid = v; in1_if.a_opcode = op; in1_if.a_size = sz;
      in1_if.a_source = src; in1_if.a_address = addr; in1_if.a_data = data;
      in1_if.a_param = 3'd0; in1_if.a_mask = 8'hFF; in1_if.a_corrupt = 1'b0;
    end
  endtask

  task automatic idle_all();
    set_a(0, 1'b0, 3'd0, 3'd0, 2'd0, 26'd0, 64'd0);
    set_a(1, 1'b0, 3'd0, 3'd0, 2'd0, 26'd0, 64'd0);
    in0_if.a_mask = 8'h00; in1_if.a_mask = 8'h00;
    in0_if.d_ready = 1'b0; in1_if.d_ready = 1'b0;
    out_if.a_ready = 1'b0;
    out_if.d_valid = 1'b0; out_if.d_opcode = 3'd0; out_if.d_size = 3'd0;
    out_if.d_source = 3'd0; out_if.d_data = 64'd0;
  endtask

  initial begin
    idle_all();
    repeat (2) @(posedge clock);
    #2;
    // reset state, all inputs 0
    chk("rst_out_a_valid", 64'(out_if.a_valid), 64'd0);
    chk("rst_out_a_source", 64'(out_if.a_source), 64'd0);
    chk("rst_in0_a_ready", 64'(in0_if.a_ready), 64'd0);
    chk("rst_in1_a_ready", 64'(in1_if.a_ready), 64'd0);
    chk("rst_out_d_ready", 64'(out_if.d_ready), 64'd0);
    chk("rst_in0_d_valid", 64'(in0_if.d_valid), 64'd0);
    chk("rst_last", 64'(dut.last), 64'd1);
    tick();
    reset = 1'b1;

    // single Get from in0
    set_a(0, 1'b1, 3'd4, 3'd3, 2'd1, 26'h0000100, 64'd0);
    out_if.a_ready = 1'b1;
    #1;
    chk("get0_valid", 64'(out_if.a_valid), 64'd1);
    chk("get0_source", 64'(out_if.a_source), 64'b001);
    chk("get0_addr", 64'(out_if.a_address), 64'h100);
    chk("get0_in0_ready", 64'(in0_if.a_ready), 64'd1);
    chk("get0_in1_ready", 64'(in1_if.a_ready), 64'd0);
    tick();
    // last is now 0, so the first tie goes to in1

    // round-robin with both valid every cycle
    set_a(0, 1'b1, 3'd4, 3'd3, 2'd1, 26'h0000200, 64'd0);
    set_a(1, 1'b1, 3'd4, 3'd3, 2'd2, 26'h0000300, 64'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_source", 64'(out_if.a_source), (i % 2 == 0) ? 64'b110 : 64'b001);
      chk("rr_addr", 64'(out_if.a_address), (i % 2 == 0) ? 64'h300 : 64'h200);
      tick();
    end
    // last = 0 again

    // 4-beat Put from in1 while in0 waits
    set_a(0, 1'b1, 3'd4, 3'd3, 2'd0, 26'h0000400, 64'd0);
    for (int b = 0; b < 4; b++) begin
      set_a(1, 1'b1, 3'd0, 3'd5, 2'd3, 26'h0000500, 64'hA000 + 64'(b));
      #1;
      chk("burst_src_msb", 64'(out_if.a_source[2]), 64'd1);
      chk("burst_data", out_if.a_data, 64'hA000 + 64'(b));
      chk("burst_in0_ready", 64'(in0_if.a_ready), 64'd0);
      tick();
    end
    set_a(1, 1'b1, 3'd4, 3'd3, 2'd3, 26'h0000600, 64'd0);
    #1;
    chk("after_burst_src_msb", 64'(out_if.a_source[2]), 64'd0);
    chk("after_burst_in0_ready", 64'(in0_if.a_ready), 64'd1);
    tick();
    idle_all();
    // last = 0

    // backpressure holds the grant
    set_a(0, 1'b1, 3'd4, 3'd3, 2'd2, 26'h0000700, 64'd0);
    out_if.a_ready = 1'b0;
    #1;
    chk("hold_c1_msb", 64'(out_if.a_source[2]), 64'd0);
    tick();
    set_a(1, 1'b1, 3'd4, 3'd3, 2'd1, 26'h0000800, 64'd0);
    #1;
    chk("hold_c2_msb", 64'(out_if.a_source[2]), 64'd0);
    chk("hold_c2_in1_ready", 64'(in1_if.a_ready), 64'd0);
    tick();
    #1;
    chk("hold_c3_msb", 64'(out_if.a_source[2]), 64'd0);
    tick();
    out_if.a_ready = 1'b1;
    #1;
    chk("hold_fire_msb", 64'(out_if.a_source[2]), 64'd0);
    chk("hold_fire_in0_ready", 64'(in0_if.a_ready), 64'd1);
    tick();
    #1;
    chk("hold_next_src", 64'(out_if.a_source), 64'b101);
    tick();
    idle_all();
    // last = 1

    // D routing by source MSB
    out_if.d_valid = 1'b1; out_if.d_source = 3'b110; out_if.d_opcode = 3'd1;
    out_if.d_size = 3'd4; out_if.d_data = 64'hD0D0_0001;
    in0_if.d_ready = 1'b1; in1_if.d_ready = 1'b0;
    #1;
    chk("d1_in1_valid", 64'(in1_if.d_valid), 64'd1);
    chk("d1_in0_valid", 64'(in0_if.d_valid), 64'd0);
    chk("d1_in1_source", 64'(in1_if.d_source), 64'b10);
    chk("d1_in1_opcode", 64'(in1_if.d_opcode), 64'd1);
    chk("d1_out_ready", 64'(out_if.d_ready), 64'd0);
    tick();
    in1_if.d_ready = 1'b1;
    #1;
    chk("d1b_out_ready", 64'(out_if.d_ready), 64'd1);
    tick();
    out_if.d_data = 64'hD0D0_0002;
    #1;
    chk("d2_in1_data", in1_if.d_data, 64'hD0D0_0002);
    chk("d2_in0_source", 64'(in0_if.d_source), 64'b10);
    tick();
    idle_all();

    // reset in the middle of an 8-beat Put
    out_if.a_ready = 1'b1;
    set_a(0, 1'b1, 3'd1, 3'd6, 2'd0, 26'h0000900, 64'h55);
    #1;
    chk("put8_msb", 64'(out_if.a_source[2]), 64'd0);
    tick();
    tick();
    chk("put8_lock", 64'(dut.lock), 64'd1);
    chk("put8_beats_left", 64'(dut.beats_left), 64'd5);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_lock", 64'(dut.lock), 64'd0);
    chk("mid_rst_beats_left", 64'(dut.beats_left), 64'd0);
    idle_all();
    out_if.a_ready = 1'b1;
    tick();
    reset = 1'b1;
    set_a(1, 1'b1, 3'd4, 3'd3, 2'd0, 26'h0000A00, 64'd0);
    #1;
    chk("post_rst_valid", 64'(out_if.a_valid), 64'd1);
    chk("post_rst_src", 64'(out_if.a_source), 64'b100);
    chk("post_rst_in0_ready", 64'(in0_if.a_ready), 64'd0);
    tick();
    // last = 1

    // large-size Get and size-3 Put are single beats
    set_a(0, 1'b1, 3'd4, 3'd6, 2'd1, 26'h0000B00, 64'd0);
    set_a(1, 1'b1, 3'd0, 3'd3, 2'd2, 26'h0000C00, 64'h77);
    #1;
    chk("big_get_msb", 64'(out_if.a_source[2]), 64'd0);
    tick();
    #1;
    chk("after_big_get_src", 64'(out_if.a_source), 64'b110);
    tick();
    #1;
    chk("after_put3_msb", 64'(out_if.a_source[2]), 64'd0);
    tick();
    idle_all();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
